mac_accum_pipe: RTL and testbench
=================================

# mac_accum_pipe

Parametrised, pipelined multiply-accumulate unit: each accepted sample pair (a, b) is multiplied and added into a running accumulator `f`. It extends the single-operand square-accumulate datapath with:
- configurable operand and accumulator widths;
- a configurable number of multiplier pipeline stages;
- a per-sample accumulator restart;
- sticky overflow detection with an optional saturating mode.

It sits between the sample source (valid-qualified stream) and the downstream consumer of accumulated results.

## Interface
- `W_IN`, default 8: operand width in bits (unsigned).
- `W_ACC`, default 20: accumulator and result width. Elaboration error if `W_ACC < 2*W_IN`.
- `MULT_STAGES`, default 1: product register stages, legal range 0..2.
- `SATURATE`, default 0: 0 = wrap on overflow, 1 = clamp to `2^W_ACC-1`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a`  in  `W_IN`  operand A, sampled when `valid_in=1`.
- `b`  in  `W_IN`  operand B, sampled when `valid_in=1`.
- `valid_in`  in  1  sample qualifier; may be high on consecutive cycles.
- `clear_in`  in  1  restart accumulation with this sample; ignored when `valid_in=0`.
- `f`  out  `W_ACC`  accumulated result.
- `valid_out`  out  1  one-cycle pulse per accepted sample; `f` is valid in that cycle.
- `overflow`  out  1  sticky overflow flag for the current accumulation.

## Operation
Pipeline, in order:
- Input register: captures `a`, `b`, `valid_in` and `clear_in & valid_in` every cycle.
- `MULT_STAGES` product registers: each carries the `2*W_IN`-bit product plus its valid and clear tags. With 0 stages the product is combinational from the input register.
- Accumulator register: `f`, `valid_out`, `overflow`.

Accumulator update, applied only when the tagged valid reaching the accumulator stage is 1:
- clear tag = 1: `f <= product` (zero-extended); `overflow <= 0`. The product always fits because `W_ACC >= 2*W_IN`.
- clear tag = 0: compute `sum = f + product` in `W_ACC+1` bits.
  - If `sum[W_ACC] = 0`: `f <= sum[W_ACC-1:0]`.
  - If `sum[W_ACC] = 1` and `SATURATE=0`: `f <= sum[W_ACC-1:0]` (wrap); `overflow <= 1`.
  - If `sum[W_ACC] = 1` and `SATURATE=1`: `f <= 2^W_ACC-1`; `overflow <= 1`.
- `overflow` is never cleared by a normal add. Only a clear-tagged sample or reset clears it.
- In saturating mode, once `f` is at max, later adds keep it at max and `overflow` stays 1.

When the tagged valid at the accumulator stage is 0:
- `f` and `overflow` hold their values.
- `valid_out <= 0`.

`valid_out` equals the tagged valid at the accumulator stage, registered. No backpressure: every accepted sample produces exactly one `valid_out` pulse.

## Timing
- Reset: `reset_n=0` asynchronously forces every register to 0 (operand, product, valid and clear tags, `f`, `valid_out`, `overflow`) with no clock required. Outputs read `f=0`, `valid_out=0`, `overflow=0` while reset is held.
- Latency: a sample captured at rising edge N appears on `f`/`valid_out` after edge N+1+`MULT_STAGES`, i.e. 2 cycles for the default.
- Throughput: one sample per cycle. Back-to-back samples accumulate in order with no bubbles.
- Gaps in `valid_in` propagate as gaps in `valid_out`; `f` holds through the gap.
- Reset mid-operation: in-flight samples are discarded and no `valid_out` is produced for them. The first sample after release accumulates from 0.
- `reset_n` deassertion must meet recovery/removal timing to `clk`; no internal synchronizer is provided.
- `clear_in=1` with `valid_in=0` has no effect on any state.
- A `clear_in` sample immediately following an overflowing sample: the overflowing result is output with `overflow=1`, then the next cycle shows the product with `overflow=0`.

## Test plan
All scenarios use defaults unless noted.
- Basic accumulate:
  - reset, then samples (21,21), (36,36) on consecutive cycles -> `valid_out` pulses 2 and 3 edges after the first sample, with `f=441` then `f=1737`.
  - idle 2 cycles, then (64,64) -> `f=5833`; `f` held at 1737 with `valid_out=0` during the gap.
- Clear: after the above, (2,3) with `clear_in=1` -> `f=6`, `overflow=0`. Then `clear_in=1` with `valid_in=0` -> no change, no pulse.
- Wrap overflow (`SATURATE=0`): clear, then 17 back-to-back samples of (255,255):
  - 16th result -> `f=1040400`, `overflow=0`;
  - 17th result -> `f=56849`, `overflow=1`;
  - one more (1,1) -> `f=56850`, `overflow` still 1.
- Saturate (`SATURATE=1`): same 17 samples -> 17th result `f=1048575`, `overflow=1`; an 18th sample keeps `f=1048575`. Then a clear with (1,1) -> `f=1`, `overflow=0`.
- Latency sweep: repeat the basic accumulate for `MULT_STAGES` = 0, 1 and 2 -> first `valid_out` after 1, 2 and 3 edges respectively, with identical `f` values.
- Async reset mid-stream: drive samples (10,10) on 3 consecutive cycles and pull `reset_n` low between edges while they are in flight:
  - `f=0`, `valid_out=0`, `overflow=0` immediately, with no clock;
  - after release, (5,5) -> `f=25` with a single `valid_out` pulse.

Source files
------------

// File: rtl/mac_accum_pipe_if.sv
// Sample-stream and result bus of the multiply-accumulate unit.
// The source drives operands through master; the MAC returns results through slave.
interface mac_accum_pipe_if #(
    parameter int W_IN  = 8,
    parameter int W_ACC = 20
);
    logic [W_IN-1:0]  a;
    logic [W_IN-1:0]  b;
    logic             valid_in;
    logic             clear_in;
    logic [W_ACC-1:0] f;
    logic             valid_out;
    logic             overflow;

    modport master (
        output a, b, valid_in, clear_in,
        input  f, valid_out, overflow
    );

    modport slave (
        input  a, b, valid_in, clear_in,
        output f, valid_out, overflow
    );
endinterface

// File: rtl/mac_accum_pipe.sv
// Pipelined unsigned multiply-accumulate: input register, MULT_STAGES product
// registers, then an accumulator with per-sample restart and sticky overflow.
module mac_accum_pipe #(
    parameter int W_IN        = 8,
    parameter int W_ACC       = 20,
    parameter int MULT_STAGES = 1,
    parameter int SATURATE    = 0
) (
    input logic               clk,
    input logic               reset_n,
    mac_accum_pipe_if.slave   bus
);
    localparam int W_P = 2 * W_IN;

    if (W_ACC < W_P) begin : g_bad_width
        $error("mac_accum_pipe: W_ACC must be at least 2*W_IN");
    end
    if (MULT_STAGES < 0 || MULT_STAGES > 2) begin : g_bad_stages
        $error("mac_accum_pipe: MULT_STAGES must be 0, 1 or 2");
    end

    // Input register
    logic [W_IN-1:0] a_q;
    logic [W_IN-1:0] b_q;
    logic            v_q;
    logic            c_q;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
            v_q <= 1'b0;
            c_q <= 1'b0;
        end else begin
            a_q <= bus.a;
            b_q <= bus.b;
            v_q <= bus.valid_in;
            c_q <= bus.clear_in & bus.valid_in;
        end
    end

    logic [W_P-1:0] mult;
    assign mult = {{W_IN{1'b0}}, a_q} * {{W_IN{1'b0}}, b_q};

    // Product and its tags as seen by the accumulator stage
    logic [W_P-1:0] acc_prod;
    logic           acc_v;
    logic           acc_c;

    if (MULT_STAGES == 0) begin : g_comb_mult
        assign acc_prod = mult;
        assign acc_v    = v_q;
        assign acc_c    = c_q;
    end else begin : g_reg_mult
        logic [W_P-1:0] prod_q [MULT_STAGES];
        logic           pv_q   [MULT_STAGES];
        logic           pc_q   [MULT_STAGES];

        // NOTE: these stage arrays are ordinary flops, not RAM, so they take the
        // async reset; otherwise stale valid tags would leak out after reset.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < MULT_STAGES; i++) begin
                    prod_q[i] <= '0;
                    pv_q[i]   <= 1'b0;
                    pc_q[i]   <= 1'b0;
                end
            end else begin
                prod_q[0] <= mult;
                pv_q[0]   <= v_q;
                pc_q[0]   <= c_q;
                for (int i = 1; i < MULT_STAGES; i++) begin
                    prod_q[i] <= prod_q[i-1];
                    pv_q[i]   <= pv_q[i-1];
                    pc_q[i]   <= pc_q[i-1];
                end
            end
        end

        assign acc_prod = prod_q[MULT_STAGES-1];
        assign acc_v    = pv_q[MULT_STAGES-1];
        assign acc_c    = pc_q[MULT_STAGES-1];
    end

    // Accumulator stage
    logic [W_ACC-1:0] f_q;
    logic [W_ACC-1:0] f_d;
    logic             ov_q;
    logic             ov_d;
    logic             vo_q;
    logic [W_ACC:0]   sum;

    assign sum = {1'b0, f_q} + (W_ACC+1)'(acc_prod);

    // NOTE: f_d/ov_d default to the held values first, so no path leaves them
    // unassigned and no latch is inferred.
    always_comb begin
        f_d  = f_q;
        ov_d = ov_q;
        if (acc_v) begin
            if (acc_c) begin
                f_d  = W_ACC'(acc_prod);
                ov_d = 1'b0;
            end else if (sum[W_ACC]) begin
                ov_d = 1'b1;
                f_d  = (SATURATE != 0) ? '1 : sum[W_ACC-1:0];
            end else begin
                f_d  = sum[W_ACC-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_q  <= '0;
            ov_q <= 1'b0;
            vo_q <= 1'b0;
        end else begin
            f_q  <= f_d;
            ov_q <= ov_d;
            vo_q <= acc_v;
        end
    end

    assign bus.f         = f_q;
    assign bus.overflow  = ov_q;
    assign bus.valid_out = vo_q;
endmodule

// File: tb/tb_mac_accum_pipe.sv
// Directed bench: four MAC instances (wrap/1 stage, saturate/1 stage, wrap/0 and
// wrap/2 stages) share one stimulus stream; results are hand-computed constants.
module tb_mac_accum_pipe;
    localparam int W_IN  = 8;
    localparam int W_ACC = 20;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mac_accum_pipe_if #(.W_IN(W_IN), .W_ACC(W_ACC)) if_main ();
    mac_accum_pipe_if #(.W_IN(W_IN), .W_ACC(W_ACC)) if_sat ();
    mac_accum_pipe_if #(.W_IN(W_IN), .W_ACC(W_ACC)) if_ms0 ();
    mac_accum_pipe_if #(.W_IN(W_IN), .W_ACC(W_ACC)) if_ms2 ();

    mac_accum_pipe #(.W_IN(W_IN), .W_ACC(W_ACC), .MULT_STAGES(1), .SATURATE(0))
        u_main (.clk(clk), .reset_n(reset_n), .bus(if_main));
    mac_accum_pipe #(.W_IN(W_IN), .W_ACC(W_ACC), .MULT_STAGES(1), .SATURATE(1))
        u_sat  (.clk(clk), .reset_n(reset_n), .bus(if_sat));
    mac_accum_pipe #(.W_IN(W_IN), .W_ACC(W_ACC), .MULT_STAGES(0), .SATURATE(0))
        u_ms0  (.clk(clk), .reset_n(reset_n), .bus(if_ms0));
    mac_accum_pipe #(.W_IN(W_IN), .W_ACC(W_ACC), .MULT_STAGES(2), .SATURATE(0))
        u_ms2  (.clk(clk), .reset_n(reset_n), .bus(if_ms2));

    // Basic accumulate stream and expected outputs after each of edges 1..8
    logic [7:0]  basic_a [8] = '{8'd21, 8'd36, 8'd0, 8'd0, 8'd64, 8'd0, 8'd0, 8'd0};
    logic        basic_v [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        ev_ms1  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [19:0] ef_ms1  [8] = '{20'd0, 20'd0, 20'd441, 20'd1737, 20'd1737, 20'd1737, 20'd5833, 20'd5833};
    logic        ev_ms0  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [19:0] ef_ms0  [8] = '{20'd0, 20'd441, 20'd1737, 20'd1737, 20'd1737, 20'd5833, 20'd5833, 20'd5833};
    logic        ev_ms2  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [19:0] ef_ms2  [8] = '{20'd0, 20'd0, 20'd0, 20'd441, 20'd1737, 20'd1737, 20'd1737, 20'd5833};

    task automatic set_in(input logic [7:0] a, input logic [7:0] b, input logic v, input logic c);
        if_main.a = a; if_main.b = b; if_main.valid_in = v; if_main.clear_in = c;
        if_sat.a  = a; if_sat.b  = b; if_sat.valid_in  = v; if_sat.clear_in  = c;
        if_ms0.a  = a; if_ms0.b  = b; if_ms0.valid_in  = v; if_ms0.clear_in  = c;
        if_ms2.a  = a; if_ms2.b  = b; if_ms2.valid_in  = v; if_ms2.clear_in  = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // idx: 0 = main, 1 = saturating, 2 = MULT_STAGES 0, 3 = MULT_STAGES 2
    task automatic check(input string tag, input int idx, input logic ev,
                         input logic [W_ACC-1:0] ef, input logic eo);
        logic             ov;
        logic [W_ACC-1:0] of;
        logic             oo;
        case (idx)
            0:       begin ov = if_main.valid_out; of = if_main.f; oo = if_main.overflow; end
            1:       begin ov = if_sat.valid_out;  of = if_sat.f;  oo = if_sat.overflow;  end
            2:       begin ov = if_ms0.valid_out;  of = if_ms0.f;  oo = if_ms0.overflow;  end
            default: begin ov = if_ms2.valid_out;  of = if_ms2.f;  oo = if_ms2.overflow;  end
        endcase
        n_cmp++;
        assert (ov === ev) else begin
            n_err++;
            $error("FAIL %s valid_out: observed %0b expected %0b", tag, ov, ev);
        end
        n_cmp++;
        assert (of === ef) else begin
            n_err++;
            $error("FAIL %s f: observed %0d expected %0d", tag, of, ef);
        end
        n_cmp++;
        assert (oo === eo) else begin
            n_err++;
            $error("FAIL %s overflow: observed %0b expected %0b", tag, oo, eo);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(8'd0, 8'd0, 1'b0, 1'b0);
        #1;
        for (int d = 0; d < 4; d++) check($sformatf("reset_dut%0d", d), d, 1'b0, 20'd0, 1'b0);
        #2 reset_n = 1'b1;

        // Basic accumulate plus latency sweep across stage counts
        for (int k = 0; k < 8; k++) begin
            set_in(basic_a[k], basic_a[k], basic_v[k], 1'b0);
            step();
            check($sformatf("basic%0d_main", k + 1), 0, ev_ms1[k], ef_ms1[k], 1'b0);
            check($sformatf("basic%0d_sat",  k + 1), 1, ev_ms1[k], ef_ms1[k], 1'b0);
            check($sformatf("basic%0d_ms0",  k + 1), 2, ev_ms0[k], ef_ms0[k], 1'b0);
            check($sformatf("basic%0d_ms2",  k + 1), 3, ev_ms2[k], ef_ms2[k], 1'b0);
        end

        // Clear-tagged sample, then clear without valid
        set_in(8'd2, 8'd3, 1'b1, 1'b1);
        step();
        check("clear_e1", 0, 1'b0, 20'd5833, 1'b0);
        set_in(8'd0, 8'd0, 1'b0, 1'b1);
        step();
        check("clear_e2", 0, 1'b0, 20'd5833, 1'b0);
        set_in(8'd0, 8'd0, 1'b0, 1'b0);
        step();
        check("clear_main", 0, 1'b1, 20'd6, 1'b0);
        check("clear_sat",  1, 1'b1, 20'd6, 1'b0);
        step();
        check("clear_noval", 0, 1'b0, 20'd6, 1'b0);

        // 17 x (255,255) from a clear, then (1,1), then clear (1,1)
        for (int i = 1; i <= 21; i++) begin
            if (i <= 17)      set_in(8'd255, 8'd255, 1'b1, i == 1);
            else if (i <= 19) set_in(8'd1, 8'd1, 1'b1, i == 19);
            else              set_in(8'd0, 8'd0, 1'b0, 1'b0);
            step();
            case (i - 2)
                16: begin
                    check("wrap16_main", 0, 1'b1, 20'd1040400, 1'b0);
                    check("wrap16_sat",  1, 1'b1, 20'd1040400, 1'b0);
                end
                17: begin
                    check("wrap17_main", 0, 1'b1, 20'd56849, 1'b1);
                    check("wrap17_sat",  1, 1'b1, 20'd1048575, 1'b1);
                end
                18: begin
                    check("wrap18_main", 0, 1'b1, 20'd56850, 1'b1);
                    check("wrap18_sat",  1, 1'b1, 20'd1048575, 1'b1);
                end
                19: begin
                    check("reclear_main", 0, 1'b1, 20'd1, 1'b0);
                    check("reclear_sat",  1, 1'b1, 20'd1, 1'b0);
                end
                default: ;
            endcase
        end

        // Asynchronous reset with samples in flight
        set_in(8'd10, 8'd10, 1'b1, 1'b0);
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) check($sformatf("async_rst_dut%0d", d), d, 1'b0, 20'd0, 1'b0);
        set_in(8'd0, 8'd0, 1'b0, 1'b0);
        step();
        step();
        check("rst_held", 0, 1'b0, 20'd0, 1'b0);
        #2 reset_n = 1'b1;
        set_in(8'd5, 8'd5, 1'b1, 1'b0);
        step();
        check("post_rst_e1", 0, 1'b0, 20'd0, 1'b0);
        set_in(8'd0, 8'd0, 1'b0, 1'b0);
        step();
        check("post_rst_e2", 0, 1'b0, 20'd0, 1'b0);
        step();
        check("post_rst_result", 0, 1'b1, 20'd25, 1'b0);
        step();
        check("post_rst_single", 0, 1'b0, 20'd25, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
